// File: rtl/mem_stage.sv
// mem_stage: data-memory stage for single (LDR/STR) and block (LDM/STM) transfers.
// Drives the data-cache port, generates base-register writeback and stalls Execute
// while a transfer is in flight. Non-memory instructions pass through in one cycle.
// Optional feature: define MEMSTAGE_UNALIGNED_ROTATE_EN to rotate unaligned word loads.
module mem_stage (
    input  logic        clk,
    input  logic        Nrst,
    input  logic        stall,
    input  logic        flush,
    input  logic        inbubble,
    input  logic [31:0] insn,
    input  logic [31:0] base,
    input  logic [31:0] offset,
    input  logic [31:0] st_data,
    input  logic        in_write_reg,
    input  logic [3:0]  in_write_num,
    input  logic [31:0] in_write_data,
    output logic [3:0]  rf_sel,
    input  logic [31:0] rf_data,
    output logic [31:0] dc_addr,
    output logic        dc_rd_req,
    output logic        dc_wr_req,
    output logic [3:0]  dc_be,
    output logic [31:0] dc_wdata,
    input  logic [31:0] dc_rdata,
    input  logic        dc_ready,
    output logic        outstall,
    output logic        outbubble,
    output logic        write_reg,
    output logic [3:0]  write_num,
    output logic [31:0] write_data,
    output logic        wb_reg,
    output logic [3:0]  wb_num,
    output logic [31:0] wb_data
);

    typedef enum logic [0:0] {StIdle, StAccess} state_e;

    typedef struct packed {
        logic        bubble;
        logic        wr;
        logic [3:0]  wn;
        logic [31:0] wd;
        logic        wb;
        logic [3:0]  bn;
        logic [31:0] bd;
    } out_t;

    function automatic logic [3:0] lowest_bit(input logic [15:0] l);
        lowest_bit = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (l[i]) lowest_bit = 4'(i);
        end
    endfunction

    function automatic logic [4:0] popcount(input logic [15:0] l);
        popcount = 5'd0;
        for (int i = 0; i < 16; i++) popcount = popcount + 5'(l[i]);
    endfunction

    state_e      state_q;
    out_t        out_q, skid_q, res;
    logic        skid_vld_q;
    logic        rd_q, wr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] addr_q;
    logic [15:0] list_q;       // remaining beats; single transfers use a one-bit list
    logic        load_q, blk_q, byte_q, wb_en_q;
    logic [3:0]  rd_num_q, wb_num_q;
    logic [31:0] wb_val_q;

    logic        is_single, is_block, take, mem_start;
    logic        p_bit, u_bit, b_bit, w_bit, l_bit;
    logic [4:0]  n;
    logic [31:0] n4, ea, s_addr, b_addr, b_wb;
    logic        beat, final_beat;
    logic [15:0] list_nxt;
    logic [5:0]  sh;
    logic [31:0] word_data, byte_data, ld_data;
    logic        unused_ok;

    // Decode the incoming instruction and precompute addresses.
    always_comb begin
        is_single = insn[27:26] == 2'b01;
        is_block  = insn[27:25] == 3'b100;
        p_bit     = insn[24];
        u_bit     = insn[23];
        b_bit     = insn[22];
        w_bit     = insn[21];
        l_bit     = insn[20];
        n         = popcount(insn[15:0]);
        n4        = {25'd0, n, 2'b00};
        ea        = u_bit ? base + offset : base - offset;
        s_addr    = p_bit ? ea : base;
        b_addr    = u_bit ? base + (p_bit ? 32'd4 : 32'd0)
                          : base - n4 + (p_bit ? 32'd0 : 32'd4);
        b_wb      = u_bit ? base + n4 : base - n4;
        take      = !flush && !inbubble;
        // An empty block list is not a memory access at all.
        mem_start = take && (is_single || (is_block && n != 5'd0));
    end

    assign outstall = stall || (state_q == StAccess) || (state_q == StIdle && mem_start);

    // Result of a completing beat, plus the next STM register to read.
    always_comb begin
        beat       = (state_q == StAccess) && (rd_q || wr_q) && dc_ready;
        list_nxt   = list_q & (list_q - 16'd1);
        final_beat = list_nxt == 16'd0;
        sh         = {1'b0, addr_q[1:0], 3'b000};
        byte_data  = {24'd0, dc_rdata[sh[4:0] +: 8]};
`ifdef MEMSTAGE_UNALIGNED_ROTATE_EN
        word_data  = (dc_rdata >> sh) | (dc_rdata << (6'd32 - sh));
`else
        word_data  = dc_rdata;
`endif
        ld_data    = blk_q ? dc_rdata : (byte_q ? byte_data : word_data);
        res.bubble = !(load_q || final_beat);
        res.wr     = load_q;
        res.wn     = blk_q ? lowest_bit(list_q) : rd_num_q;
        res.wd     = ld_data;
        res.wb     = wb_en_q && final_beat;
        res.bn     = wb_num_q;
        res.bd     = wb_val_q;
        if (state_q == StIdle) rf_sel = lowest_bit(insn[15:0]);
        else if (beat)         rf_sel = lowest_bit(list_nxt);
        else                   rf_sel = lowest_bit(list_q);
    end

    // Single FSM: accept, issue cache requests, collect beats, skid under stall.
    always_ff @(posedge clk or negedge Nrst) begin
        if (!Nrst) begin
            state_q    <= StIdle;
            out_q      <= '{bubble: 1'b1, default: '0};
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= '0;
            addr_q     <= '0;
            list_q     <= '0;
            load_q     <= 1'b0;
            blk_q      <= 1'b0;
            byte_q     <= 1'b0;
            wb_en_q    <= 1'b0;
            rd_num_q   <= '0;
            wb_num_q   <= '0;
            wb_val_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!stall) begin
                        out_q.bubble <= 1'b1;
                        out_q.wr     <= 1'b0;
                        out_q.wb     <= 1'b0;
                        if (take && !is_single && !is_block) begin
                            out_q.bubble <= 1'b0;
                            out_q.wr     <= in_write_reg;
                            out_q.wn     <= in_write_num;
                            out_q.wd     <= in_write_data;
                        end else if (mem_start) begin
                            state_q  <= StAccess;
                            load_q   <= l_bit;
                            blk_q    <= is_block;
                            byte_q   <= is_single && b_bit;
                            rd_num_q <= insn[15:12];
                            list_q   <= is_block ? insn[15:0] : 16'h0001;
                            addr_q   <= is_block ? b_addr : s_addr;
                            wb_en_q  <= is_block ? w_bit : (w_bit || !p_bit);
                            wb_num_q <= insn[19:16];
                            wb_val_q <= is_block ? b_wb : ea;
                            rd_q     <= l_bit;
                            wr_q     <= !l_bit;
                            if (l_bit)                  be_q <= 4'h0;
                            else if (is_block || !b_bit) be_q <= 4'hF;
                            else                        be_q <= 4'b0001 << s_addr[1:0];
                            if (is_block)   wdata_q <= rf_data;
                            else if (b_bit) wdata_q <= {4{st_data[7:0]}};
                            else            wdata_q <= st_data;
                        end
                    end
                end
                StAccess: begin
                    if (beat) begin
                        rd_q   <= 1'b0;
                        wr_q   <= 1'b0;
                        list_q <= list_nxt;
                        addr_q <= addr_q + 32'd4;
                        if (stall) begin
                            skid_q     <= res;
                            skid_vld_q <= 1'b1;
                        end else begin
                            out_q <= res;
                            if (final_beat) begin
                                state_q <= StIdle;
                            end else begin
                                rd_q    <= load_q;
                                wr_q    <= !load_q;
                                be_q    <= load_q ? 4'h0 : 4'hF;
                                wdata_q <= rf_data;
                            end
                        end
                    end else if (!(rd_q || wr_q)) begin
                        // Request dropped under stall: drain skid, then finish or re-raise.
                        if (!stall) begin
                            if (skid_vld_q) begin
                                out_q      <= skid_q;
                                skid_vld_q <= 1'b0;
                            end else begin
                                out_q.bubble <= 1'b1;
                                out_q.wr     <= 1'b0;
                                out_q.wb     <= 1'b0;
                            end
                            if (list_q == 16'd0) begin
                                state_q <= StIdle;
                            end else begin
                                rd_q    <= load_q;
                                wr_q    <= !load_q;
                                be_q    <= load_q ? 4'h0 : 4'hF;
                                wdata_q <= rf_data;
                            end
                        end
                    end else if (!stall) begin
                        out_q.bubble <= 1'b1;
                        out_q.wr     <= 1'b0;
                        out_q.wb     <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign dc_addr    = {addr_q[31:2], 2'b00};
    assign dc_rd_req  = rd_q;
    assign dc_wr_req  = wr_q;
    assign dc_be      = be_q;
    assign dc_wdata   = wdata_q;
    assign outbubble  = out_q.bubble;
    assign write_reg  = out_q.wr;
    assign write_num  = out_q.wn;
    assign write_data = out_q.wd;
    assign wb_reg     = out_q.wb;
    assign wb_num     = out_q.bn;
    assign wb_data    = out_q.bd;

    assign unused_ok = ^{insn[31:28], sh[5]};

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected cache requests and
// Writeback outputs; monitors pop and compare on dc_ready and on consumed outputs.
module tb_mem_stage;

    logic        clk, Nrst, stall, flush, inbubble;
    logic [31:0] insn, base, offset, st_data;
    logic        in_write_reg;
    logic [3:0]  in_write_num;
    logic [31:0] in_write_data;
    logic [3:0]  rf_sel;
    logic [31:0] rf_data;
    logic [31:0] dc_addr;
    logic        dc_rd_req, dc_wr_req;
    logic [3:0]  dc_be;
    logic [31:0] dc_wdata, dc_rdata;
    logic        dc_ready;
    logic        outstall, outbubble;
    logic        write_reg;
    logic [3:0]  write_num;
    logic [31:0] write_data;
    logic        wb_reg;
    logic [3:0]  wb_num;
    logic [31:0] wb_data;

    typedef struct {
        logic        wr;
        logic [3:0]  wn;
        logic [31:0] wd;
        logic        wb;
        logic [3:0]  bn;
        logic [31:0] bd;
    } exp_out_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_req_t;

    exp_out_t out_sb[$];
    exp_req_t req_sb[$];
    int pass_cnt = 0;
    int total_cnt = 0;

    mem_stage dut (
        .clk(clk), .Nrst(Nrst), .stall(stall), .flush(flush), .inbubble(inbubble),
        .insn(insn), .base(base), .offset(offset), .st_data(st_data),
        .in_write_reg(in_write_reg), .in_write_num(in_write_num),
        .in_write_data(in_write_data), .rf_sel(rf_sel), .rf_data(rf_data),
        .dc_addr(dc_addr), .dc_rd_req(dc_rd_req), .dc_wr_req(dc_wr_req), .dc_be(dc_be),
        .dc_wdata(dc_wdata), .dc_rdata(dc_rdata), .dc_ready(dc_ready),
        .outstall(outstall), .outbubble(outbubble), .write_reg(write_reg),
        .write_num(write_num), .write_data(write_data), .wb_reg(wb_reg),
        .wb_num(wb_num), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: each register reads as 0x5200_00<num>.
    always_comb rf_data = 32'h5200_0000 | {28'd0, rf_sel};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    task automatic push_out(input logic wr, input logic [3:0] wn, input logic [31:0] wd,
                            input logic wb, input logic [3:0] bn, input logic [31:0] bd);
        exp_out_t e;
        e.wr = wr; e.wn = wn; e.wd = wd; e.wb = wb; e.bn = bn; e.bd = bd;
        out_sb.push_back(e);
    endtask

    task automatic push_req(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        exp_req_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wdata;
        req_sb.push_back(e);
    endtask

    // Output monitor: an output is consumed in a cycle where stall is low.
    always @(negedge clk) begin
        exp_out_t eo;
        exp_req_t er;
        if (Nrst) begin
            if (!stall && !outbubble) begin
                if (out_sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_out: got wr=%0d num=%0d data=%h wb=%0d, required none",
                             write_reg, write_num, write_data, wb_reg);
                end else begin
                    eo = out_sb.pop_front();
                    chk("write_reg", {31'd0, write_reg}, {31'd0, eo.wr});
                    if (eo.wr) begin
                        chk("write_num", {28'd0, write_num}, {28'd0, eo.wn});
                        chk("write_data", write_data, eo.wd);
                    end
                    chk("wb_reg", {31'd0, wb_reg}, {31'd0, eo.wb});
                    if (eo.wb) begin
                        chk("wb_num", {28'd0, wb_num}, {28'd0, eo.bn});
                        chk("wb_data", wb_data, eo.bd);
                    end
                end
            end
            if ((dc_rd_req || dc_wr_req) && dc_ready) begin
                if (req_sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_req: got addr=%h rd=%0d wr=%0d, required none",
                             dc_addr, dc_rd_req, dc_wr_req);
                end else begin
                    er = req_sb.pop_front();
                    chk("dc_wr_req", {31'd0, dc_wr_req}, {31'd0, er.we});
                    chk("dc_rd_req", {31'd0, dc_rd_req}, {31'd0, !er.we});
                    chk("dc_addr", dc_addr, er.addr);
                    if (er.we) begin
                        chk("dc_be", {28'd0, dc_be}, {28'd0, er.be});
                        chk("dc_wdata", dc_wdata, er.wdata);
                    end
                end
            end
        end
    end

    // Present one instruction for a single cycle; checks outstall in the accept cycle.
    task automatic issue(input logic [31:0] i, input logic [31:0] b, input logic [31:0] o,
                         input logic [31:0] sd, input logic iw, input logic [3:0] inum,
                         input logic [31:0] idata, input logic fl, input logic exp_stall);
        insn = i; base = b; offset = o; st_data = sd;
        in_write_reg = iw; in_write_num = inum; in_write_data = idata;
        flush = fl; inbubble = 1'b0;
        #1;
        chk("outstall_accept", {31'd0, outstall}, {31'd0, exp_stall});
        @(posedge clk); #1;
        inbubble = 1'b1; flush = 1'b0; in_write_reg = 1'b0;
    endtask

    // Complete the outstanding request after lat cycles, optionally stalling on dc_ready.
    task automatic serve(input logic [31:0] rdata, input int lat, input logic stall_rdy,
                         input int stall_len);
        int t = 0;
        while (!(dc_rd_req || dc_wr_req) && t < 50) begin
            @(posedge clk); #1; t++;
        end
        chk("req_seen", {31'd0, dc_rd_req || dc_wr_req}, 32'd1);
        repeat (lat) begin
            chk("outstall_busy", {31'd0, outstall}, 32'd1);
            @(posedge clk); #1;
        end
        dc_ready = 1'b1; dc_rdata = rdata;
        if (stall_rdy) stall = 1'b1;
        @(posedge clk); #1;
        dc_ready = 1'b0; dc_rdata = 32'h0;
        if (stall_rdy) begin
            repeat (stall_len - 1) begin
                chk("req_dropped_in_skid", {31'd0, dc_rd_req || dc_wr_req}, 32'd0);
                chk("out_held_in_skid", {31'd0, outbubble}, 32'd1);
                @(posedge clk); #1;
            end
            stall = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Nrst = 1'b0; stall = 1'b0; flush = 1'b0; inbubble = 1'b1;
        insn = '0; base = '0; offset = '0; st_data = '0;
        in_write_reg = 1'b0; in_write_num = '0; in_write_data = '0;
        dc_rdata = '0; dc_ready = 1'b0;
        idle(2);
        chk("rst_outbubble", {31'd0, outbubble}, 32'd1);
        chk("rst_write_reg", {31'd0, write_reg}, 32'd0);
        chk("rst_wb_reg", {31'd0, wb_reg}, 32'd0);
        chk("rst_rd_req", {31'd0, dc_rd_req}, 32'd0);
        chk("rst_wr_req", {31'd0, dc_wr_req}, 32'd0);
        chk("rst_be", {28'd0, dc_be}, 32'd0);
        Nrst = 1'b1;
        idle(1);

        // Pass-through ADD: r3 = 0xCAFEF00D one cycle later.
        push_out(1'b1, 4'd3, 32'hCAFEF00D, 1'b0, 4'd0, 32'd0);
        issue(32'hE0811002, 32'd0, 32'd0, 32'd0, 1'b1, 4'd3, 32'hCAFEF00D, 1'b0, 1'b0);
        idle(2);

        // Flushed LDR: bubble, no cache request, no stall.
        issue(32'hE5B21004, 32'h1000, 32'd4, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        chk("flush_no_req", {31'd0, dc_rd_req}, 32'd0);
        chk("flush_bubble", {31'd0, outbubble}, 32'd1);
        idle(1);

        // LDR r1,[r2,#4]!
        push_req(1'b0, 32'h1004, 4'h0, 32'd0);
        push_out(1'b1, 4'd1, 32'hDEADBEEF, 1'b1, 4'd2, 32'h1004);
        issue(32'hE5B21004, 32'h1000, 32'd4, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        serve(32'hDEADBEEF, 2, 1'b0, 0);
        chk("ldr_stall_released", {31'd0, outstall}, 32'd0);
        idle(2);

        // STRB r3,[r4],#1
        push_req(1'b1, 32'h2000, 4'b1000, 32'h78787878);
        push_out(1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'h2004);
        issue(32'hE4C43001, 32'h2003, 32'd1, 32'h12345678, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        serve(32'd0, 1, 1'b0, 0);
        idle(2);

        // LDMIA r0!,{r1,r5,r7}
        push_req(1'b0, 32'h100, 4'h0, 32'd0);
        push_req(1'b0, 32'h104, 4'h0, 32'd0);
        push_req(1'b0, 32'h108, 4'h0, 32'd0);
        push_out(1'b1, 4'd1, 32'h1111_0001, 1'b0, 4'd0, 32'd0);
        push_out(1'b1, 4'd5, 32'h1111_0005, 1'b0, 4'd0, 32'd0);
        push_out(1'b1, 4'd7, 32'h1111_0007, 1'b1, 4'd0, 32'h10C);
        issue(32'hE8B000A2, 32'h100, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        serve(32'h1111_0001, 0, 1'b0, 0);
        serve(32'h1111_0005, 1, 1'b0, 0);
        serve(32'h1111_0007, 0, 1'b0, 0);
        idle(2);

        // STMDB sp!,{r4,lr}
        push_req(1'b1, 32'h7FF8, 4'hF, 32'h5200_0004);
        push_req(1'b1, 32'h7FFC, 4'hF, 32'h5200_000E);
        push_out(1'b0, 4'd0, 32'd0, 1'b1, 4'd13, 32'h7FF8);
        issue(32'hE92D4010, 32'h8000, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        serve(32'd0, 0, 1'b0, 0);
        serve(32'd0, 0, 1'b0, 0);
        idle(2);

        // Unaligned word load LDR r6,[r7,#1] at 0x1001.
        push_req(1'b0, 32'h1000, 4'h0, 32'd0);
`ifdef MEMSTAGE_UNALIGNED_ROTATE_EN
        push_out(1'b1, 4'd6, 32'h44112233, 1'b0, 4'd0, 32'd0);
`else
        push_out(1'b1, 4'd6, 32'h11223344, 1'b0, 4'd0, 32'd0);
`endif
        issue(32'hE5976001, 32'h1000, 32'd1, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        serve(32'h11223344, 0, 1'b0, 0);
        idle(2);

        // LDRB r8,[r9,#2]: lane 2 zero-extended.
        push_req(1'b0, 32'h3000, 4'h0, 32'd0);
        push_out(1'b1, 4'd8, 32'h0000_00BB, 1'b0, 4'd0, 32'd0);
        issue(32'hE5D98002, 32'h3000, 32'd2, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        serve(32'hAABBCCDD, 1, 1'b0, 0);
        idle(2);

        // LDM with empty list: no access, no stall, bubble.
        issue(32'hE8B00000, 32'h200, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        chk("n0_no_req", {31'd0, dc_rd_req}, 32'd0);
        chk("n0_bubble", {31'd0, outbubble}, 32'd1);
        idle(2);

        // Stall on dc_ready for 3 cycles: result held in skid until stall falls.
        push_req(1'b0, 32'h4000, 4'h0, 32'd0);
        push_out(1'b1, 4'd1, 32'h55AA55AA, 1'b0, 4'd0, 32'd0);
        issue(32'hE5921000, 32'h4000, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        serve(32'h55AA55AA, 0, 1'b1, 3);
        idle(3);

        // Reset mid-LDMIA r0,{r1,r2,r3}: only the first beat completes.
        push_req(1'b0, 32'h500, 4'h0, 32'd0);
        push_out(1'b1, 4'd1, 32'h0000_0501, 1'b0, 4'd0, 32'd0);
        issue(32'hE890000E, 32'h500, 32'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        serve(32'h0000_0501, 0, 1'b0, 0);
        idle(1);
        chk("second_beat_pending", {31'd0, dc_rd_req}, 32'd1);
        Nrst = 1'b0;
        #1;
        chk("async_req_drop", {31'd0, dc_rd_req}, 32'd0);
        chk("async_outbubble", {31'd0, outbubble}, 32'd1);
        chk("async_write_reg", {31'd0, write_reg}, 32'd0);
        idle(1);
        Nrst = 1'b1;
        idle(1);
        chk("post_rst_idle", {31'd0, outstall}, 32'd0);
        idle(2);
        push_out(1'b1, 4'd9, 32'h0000_0099, 1'b0, 4'd0, 32'd0);
        issue(32'hE1A00000, 32'd0, 32'd0, 32'd0, 1'b1, 4'd9, 32'h0000_0099, 1'b0, 1'b0);
        idle(3);

        chk("out_sb_empty", out_sb.size(), 32'd0);
        chk("req_sb_empty", req_sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Pipeline stage directly downstream of Execute. It performs the data-memory side of single (LDR/STR) and block (LDM/STM) transfers against the data-cache port and generates base-register writeback. Non-memory instructions pass through Execute's register write unchanged. It stalls Execute for multi-cycle transfers and presents at most one register-file write plus one base-writeback per cycle to Writeback.

## Interface
- No parameters.
- clk  in  1  stage clock
- Nrst  in  1  asynchronous active-low reset
- stall  in  1  downstream stall; hold all registered outputs
- flush  in  1  convert the instruction being accepted this cycle to a bubble
- inbubble  in  1  incoming slot is empty
- insn  in  32  instruction from Execute
- base  in  32  Rn value
- offset  in  32  resolved offset: immediate, or shifted Rm
- st_data  in  32  Rd value for STR
- in_write_reg / in_write_num / in_write_data  in  1/4/32  Execute's register write
- rf_sel  out  4  STM register-file read select
- rf_data  in  32  combinational read data for rf_sel
- dc_addr  out  32  cache address, word-aligned
- dc_rd_req, dc_wr_req  out  1  cache requests; held until dc_ready
- dc_be  out  4  write byte enables
- dc_wdata  out  32  write data
- dc_rdata  in  32  read data, valid with dc_ready
- dc_ready  in  1  request completes this cycle
- outstall  out  1  stall to Execute (combinational)
- outbubble  out  1  output slot empty
- write_reg / write_num / write_data  out  1/4/32  register write to Writeback
- wb_reg / wb_num / wb_data  out  1/4/32  base-writeback port

## Operation
- Reset values: outbubble=1, write_reg=0, wb_reg=0, dc_rd_req=0, dc_wr_req=0, dc_be=0, state=IDLE. Data outputs are don't-care.
- Accept rule: in IDLE with stall=0, the instruction is accepted. flush or inbubble makes the output a bubble.
- Non-memory instructions: forward the in_write_* fields with 1-cycle latency; no state change.
- LDR/STR (insn[27:26]=01):
  - ea = base ± offset, using U = insn[23].
  - Access address = P (insn[24]) ? ea : base.
  - Base writeback when W (insn[21]) or !P: wb_num = insn[19:16], wb_data = ea.
- Byte store (insn[22]=1): dc_be = one-hot of addr[1:0]; byte replicated on all lanes. Word store: dc_be = 4'hF.
- Byte load: select the lane addressed by addr[1:0] and zero-extend.
- Word load: see Configuration.
- Load destination: write_num = insn[15:12].
- LDM/STM (insn[27:25]=100):
  - n = popcount(insn[15:0]).
  - Start address: U ? base + (P?4:0) : base − 4n + (P?0:4).
  - Registers transfer ascending, lowest register at lowest address, one beat per dc_ready.
  - Writeback value: base ± 4n.
- Each LDM beat emits one non-bubble output carrying that register's write. The final beat also carries wb_*.
- n=0 block transfer: no cache access, bubble output, no writeback.
- States:
  - IDLE → ACCESS on an accepted memory instruction.
  - ACCESS → IDLE on the final dc_ready.
  - ACCESS stays on non-final dc_ready, advancing address by 4 and clearing the lowest remaining list bit.
- Address widths are 32-bit, modulo 2^32; wrap-around is not flagged.

## Timing
- Pass-through latency: 1 cycle.
- Single transfer: request asserted the cycle after accept. Result is registered on the dc_ready edge and visible the next cycle.
- outstall = stall | (state==ACCESS) | (accepting a memory instruction with n≠0).
- Request rules:
  - A new request is raised only when stall=0.
  - An outstanding request stays asserted, with constant address and data, until dc_ready.
  - If stall=1 when dc_ready arrives, the result is held in a skid register and presented when stall falls.
- flush affects only the accept cycle. A transfer already in ACCESS completes.
- Nrst low mid-transfer: requests drop asynchronously, state returns to IDLE, and partial writes are not emitted.
- STM: rf_sel = lowest remaining register, registered into dc_wdata when the request is raised.

## Configuration
- MEMSTAGE_UNALIGNED_ROTATE_EN defined: a word load with addr[1:0]≠0 returns dc_rdata rotated right by 8·addr[1:0].
- Undefined: addr[1:0] is ignored and the word is returned unrotated.
- Either way, dc_addr[1:0] = 0.

## Test plan
- LDR r1,[r2,#4]! with base=0x1000 and dc_rdata=0xDEADBEEF → dc_addr=0x1004; write r1=0xDEADBEEF; wb r2=0x1004; outstall high until dc_ready.
- STRB r3,[r4],#1 with base=0x2003 and r3=0x12345678 → dc_addr=0x2000, dc_be=4'b1000, dc_wdata=0x78787878; wb r4=0x2004.
- LDMIA r0!,{r1,r5,r7} with base=0x100 → addresses 0x100, 0x104, 0x108; three write beats r1, r5, r7; wb r0=0x10C on the last beat.
- STMDB sp!,{r4,lr} with sp=0x8000 → stores at 0x7FF8 (r4) and 0x7FFC (lr); wb sp=0x7FF8.
- LDR at 0x1001, dc_rdata=0x11223344 → 0x44112233 with the macro defined, 0x11223344 without.
- Assert stall on the dc_ready cycle for 3 cycles, then pulse Nrst low mid-LDM → held data appears when stall drops; after reset outbubble=1, dc_rd_req=0, state IDLE.
